// File: rtl/alu_pkg.sv
// Shared definitions for the ALU core: op encodings, FSM states and flag bit positions.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_ADC = 3'b001,
        OP_SUB = 3'b010,
        OP_SBB = 3'b011,
        OP_AND = 3'b100,
        OP_OR  = 3'b101,
        OP_XOR = 3'b110,
        OP_NOT = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_EXEC   = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_V = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_Z = 0;

endpackage

// File: rtl/alu_adder.sv
// WIDTH-bit adder with carry-in, producing carry-out and signed overflow.
module alu_adder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    logic [WIDTH:0] full;

    always_comb begin
        full = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        sum  = full[WIDTH-1:0];
        cout = full[WIDTH];
        // Overflow: both operands share a sign that the sum does not.
        ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);
    end

endmodule

// File: rtl/alu_core.sv
// Multi-cycle ALU: accepts an op, waits one settle cycle for the upstream LHS, then registers result and flags.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             alu_clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] lhs_in,
    input  logic             lhs_carry,
    input  logic [WIDTH-1:0] rhs_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [WIDTH-1:0] rhs_q, rhs_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [3:0]       flags_q, flags_d;

    logic [WIDTH-1:0] add_b, add_sum, res_calc;
    logic             add_cin, add_cout, add_ovf;
    logic [3:0]       flags_calc;
    logic             accept;

    // Subtraction is lhs + ~rhs + carry-in, so C=1 means no borrow.
    always_comb begin
        add_b   = rhs_q;
        add_cin = 1'b0;
        case (op_q)
            OP_ADC: add_cin = lhs_carry;
            OP_SUB: begin add_b = ~rhs_q; add_cin = 1'b1;      end
            OP_SBB: begin add_b = ~rhs_q; add_cin = lhs_carry; end
            default: ;
        endcase
    end

    alu_adder #(.WIDTH(WIDTH)) u_adder (
        .a    (lhs_in),
        .b    (add_b),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout),
        .ovf  (add_ovf)
    );

    always_comb begin
        res_calc           = add_sum;
        flags_calc         = '0;
        flags_calc[FLAG_C] = add_cout;
        flags_calc[FLAG_V] = add_ovf;
        case (op_q)
            OP_AND: res_calc = lhs_in & rhs_q;
            OP_OR:  res_calc = lhs_in | rhs_q;
            OP_XOR: res_calc = lhs_in ^ rhs_q;
            OP_NOT: res_calc = ~lhs_in;
            default: ;
        endcase
        if (op_q[2]) begin
            flags_calc[FLAG_C] = 1'b0;
            flags_calc[FLAG_V] = 1'b0;
        end
        flags_calc[FLAG_N] = res_calc[WIDTH-1];
        flags_calc[FLAG_Z] = (res_calc == '0);
    end

    always_ff @(posedge alu_clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_ADD;
            rhs_q    <= '0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            rhs_q    <= rhs_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    assign accept = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: state_d = accept ? ST_SETTLE : ST_IDLE;
            ST_SETTLE:        state_d = ST_EXEC;
            ST_EXEC:          state_d = ST_DONE;
            default:          state_d = ST_IDLE;
        endcase
    end

    // Operand latches move only on accept; result/flags only on the EXEC edge.
    always_comb begin
        op_d     = op_q;
        rhs_d    = rhs_q;
        result_d = result_q;
        flags_d  = flags_q;
        if (accept) begin
            op_d  = op_e'(op);
            rhs_d = rhs_in;
        end
        if (state_q == ST_EXEC) begin
            result_d = res_calc;
            flags_d  = flags_calc;
        end
    end

    always_comb begin
        busy   = (state_q == ST_SETTLE) || (state_q == ST_EXEC);
        done   = (state_q == ST_DONE);
        result = result_q;
        flags  = flags_q;
    end

endmodule

// File: tb/tb_alu_core.sv
// Self-checking bench for alu_core: directed corner cases plus randomized ops against an arithmetic model.
module tb_alu_core;

    localparam int W    = 8;
    localparam int MAX  = (1 << W) - 1;
    localparam int HALF = 1 << (W - 1);

    logic         alu_clk;
    logic         reset;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] lhs_in;
    logic         lhs_carry;
    logic [W-1:0] rhs_in;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic [3:0]   flags;

    int checks = 0;
    int errors = 0;

    alu_core #(.WIDTH(W)) dut (
        .alu_clk   (alu_clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .lhs_in    (lhs_in),
        .lhs_carry (lhs_carry),
        .rhs_in    (rhs_in),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .flags     (flags)
    );

    initial alu_clk = 1'b0;
    always #5 alu_clk = ~alu_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int sx(input int x);
        return (x >= HALF) ? x - (MAX + 1) : x;
    endfunction

    // Returns {result, N, V, C, Z} from plain integer arithmetic.
    function automatic logic [W+3:0] model(input logic [2:0] o, input logic [W-1:0] lv,
                                           input logic [W-1:0] rv, input logic cv);
        int l, r, c, full, sres, res;
        logic arith, n, v, cy, z;
        l = int'(lv); r = int'(rv); c = cv ? 1 : 0;
        full = 0; sres = 0; arith = 1'b1;
        case (o)
            3'd0: begin full = l + r;             sres = sx(l) + sx(r);         end
            3'd1: begin full = l + r + c;         sres = sx(l) + sx(r) + c;     end
            3'd2: begin full = l + (MAX - r) + 1; sres = sx(l) - sx(r);         end
            3'd3: begin full = l + (MAX - r) + c; sres = sx(l) - sx(r) - 1 + c; end
            3'd4: begin full = l & r; arith = 1'b0; end
            3'd5: begin full = l | r; arith = 1'b0; end
            3'd6: begin full = l ^ r; arith = 1'b0; end
            default: begin full = MAX - l; arith = 1'b0; end
        endcase
        res = full % (MAX + 1);
        cy  = arith && (full > MAX);
        v   = arith && ((sres > HALF - 1) || (sres < -HALF));
        n   = res >= HALF;
        z   = res == 0;
        return {W'(res), n, v, cy, z};
    endfunction

    // Full transaction: accept, SETTLE, EXEC, DONE, back to IDLE.
    task automatic do_op(input string tag, input logic [2:0] o, input logic [W-1:0] l,
                         input logic [W-1:0] r, input logic c,
                         input logic [W-1:0] exp_res, input logic [3:0] exp_flags);
        logic [W-1:0] junk;
        @(negedge alu_clk);
        start = 1'b1; op = o; rhs_in = r;
        lhs_in = W'($urandom); lhs_carry = 1'($urandom);
        @(posedge alu_clk); #1;
        check($sformatf("%s.busy_settle", tag), 32'(busy), 32'd1);
        check($sformatf("%s.done_settle", tag), 32'(done), 32'd0);
        @(negedge alu_clk);
        start = 1'b0; op = 3'($urandom); junk = W'($urandom); rhs_in = junk;
        lhs_in = l; lhs_carry = c;
        @(posedge alu_clk); #1;
        check($sformatf("%s.busy_exec", tag), 32'(busy), 32'd1);
        @(posedge alu_clk); #1;
        check($sformatf("%s.done", tag), 32'(done), 32'd1);
        check($sformatf("%s.busy_done", tag), 32'(busy), 32'd0);
        check($sformatf("%s.result", tag), 32'(result), 32'(exp_res));
        check($sformatf("%s.flags", tag), 32'(flags), 32'(exp_flags));
        @(negedge alu_clk);
        lhs_in = W'($urandom); lhs_carry = 1'($urandom);
        @(posedge alu_clk); #1;
        check($sformatf("%s.done_idle", tag), 32'(done), 32'd0);
        check($sformatf("%s.result_hold", tag), 32'(result), 32'(exp_res));
    endtask

    initial begin
        logic [W+3:0] m;
        logic [2:0]   ro;
        logic [W-1:0] rl, rr;
        logic         rc;
        int           pulses;

        reset = 1'b1; start = 1'b0; op = '0; lhs_in = '0; lhs_carry = 1'b0; rhs_in = '0;
        repeat (2) @(negedge alu_clk);
        check("reset.busy", 32'(busy), 32'd0);
        check("reset.done", 32'(done), 32'd0);
        check("reset.result", 32'(result), 32'd0);
        check("reset.flags", 32'(flags), 32'd0);
        reset = 1'b0;

        do_op("add_ovf", 3'd0, 8'h7F, 8'h01, 1'b0, 8'h80, 4'b1100);
        do_op("sub_zero", 3'd2, 8'h05, 8'h05, 1'b0, 8'h00, 4'b0011);
        do_op("sub_borrow", 3'd2, 8'h00, 8'h01, 1'b0, 8'hFF, 4'b1000);
        do_op("adc_wrap", 3'd1, 8'hFF, 8'h00, 1'b1, 8'h00, 4'b0011);
        do_op("xor", 3'd6, 8'hA5, 8'hFF, 1'b1, 8'h5A, 4'b0000);
        do_op("add_wrap", 3'd0, 8'hFF, 8'h01, 1'b0, 8'h00, 4'b0011);
        do_op("not", 3'd7, 8'h00, 8'h3C, 1'b1, 8'hFF, 4'b1000);
        do_op("sbb_borrow", 3'd3, 8'h10, 8'h10, 1'b0, 8'hFF, 4'b1000);

        for (int i = 0; i < 40; i++) begin
            ro = 3'($urandom); rl = W'($urandom); rr = W'($urandom); rc = 1'($urandom);
            m = model(ro, rl, rr, rc);
            do_op($sformatf("rand%0d", i), ro, rl, rr, rc, m[W+3:4], m[3:0]);
        end

        // Starts during SETTLE/EXEC are ignored; start held in DONE is accepted.
        @(negedge alu_clk);
        start = 1'b1; op = 3'd0; rhs_in = 8'h04; lhs_in = 8'h03; lhs_carry = 1'b0;
        @(posedge alu_clk); #1;
        pulses = 0;
        @(negedge alu_clk);
        op = 3'd6; rhs_in = 8'hFF;
        @(posedge alu_clk); #1;
        pulses += done ? 1 : 0;
        @(negedge alu_clk);
        op = 3'd2; rhs_in = 8'h01;
        @(posedge alu_clk); #1;
        pulses += done ? 1 : 0;
        check("ovl.result", 32'(result), 32'h07);
        check("ovl.flags", 32'(flags), 32'h0);
        @(negedge alu_clk);
        op = 3'd5; rhs_in = 8'hF0; lhs_in = 8'h0F;
        @(posedge alu_clk); #1;
        check("ovl.reaccept_busy", 32'(busy), 32'd1);
        check("ovl.result_hold", 32'(result), 32'h07);
        @(negedge alu_clk);
        start = 1'b0; rhs_in = 8'h00;
        @(posedge alu_clk); #1;
        pulses += done ? 1 : 0;
        check("ovl.done_once", 32'(pulses), 32'd1);
        @(posedge alu_clk); #1;
        check("ovl2.done", 32'(done), 32'd1);
        check("ovl2.result", 32'(result), 32'hFF);
        check("ovl2.flags", 32'(flags), 32'b1000);

        // Reset in the middle of EXEC clears everything at once.
        @(negedge alu_clk);
        start = 1'b1; op = 3'd0; rhs_in = 8'h22; lhs_in = 8'h55;
        @(posedge alu_clk);
        @(negedge alu_clk);
        start = 1'b0;
        @(posedge alu_clk); #2;
        check("mid.busy_before", 32'(busy), 32'd1);
        reset = 1'b1; #1;
        check("mid.busy", 32'(busy), 32'd0);
        check("mid.done", 32'(done), 32'd0);
        check("mid.result", 32'(result), 32'd0);
        check("mid.flags", 32'(flags), 32'd0);
        @(negedge alu_clk);
        reset = 1'b0;
        repeat (3) begin
            @(posedge alu_clk); #1;
            check("mid.no_residual_done", 32'(done), 32'd0);
            check("mid.no_residual_result", 32'(result), 32'd0);
        end
        do_op("post_reset_add", 3'd0, 8'h10, 8'h20, 1'b0, 8'h30, 4'b0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
